// File: rtl/bytewrite_tdp_ram_mode.sv
// Byte-write true-dual-port RAM on one clock. Each port selects its write
// mode (NO_CHANGE / READ_FIRST / WRITE_FIRST). Read latency is 1 or 2; the
// second stage is gated by regce. The RAM also provides a read-valid strobe
// per port and a registered flag for same-address write collisions. On
// overlapping lanes of a collision, port A wins.
module bytewrite_tdp_ram_mode #(
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 10,
  // Derived word width; leave at its default.
  parameter int DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int WRITE_MODE_A = 0,
  parameter int WRITE_MODE_B = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enaA,
  input  logic [NUM_COL-1:0]    weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dinA,
  input  logic                  regceA,
  output logic [DATA_WIDTH-1:0] doutA,
  output logic                  doutA_vld,
  input  logic                  enaB,
  input  logic [NUM_COL-1:0]    weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinB,
  input  logic                  regceB,
  output logic [DATA_WIDTH-1:0] doutB,
  output logic                  doutB_vld,
  output logic                  coll
);

  typedef enum int {NO_CHANGE = 0, READ_FIRST = 1, WRITE_FIRST = 2} write_mode_e;

  localparam int   DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic IS_NC_A = (WRITE_MODE_A == NO_CHANGE);
  localparam logic IS_NC_B = (WRITE_MODE_B == NO_CHANGE);
  localparam logic IS_WF_A = (WRITE_MODE_A == WRITE_FIRST);
  localparam logic IS_WF_B = (WRITE_MODE_B == WRITE_FIRST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] memRdA, memRdB;
  logic [DATA_WIDTH-1:0] s1NextA, s1NextB;
  logic [DATA_WIDTH-1:0] s1A, s1B;
  logic                  rdAccA, rdAccB;
  logic                  vld1A, vld1B;
  logic                  collNow;

  // Byte-lane writes from both ports. Port B lanes are scheduled first, so
  // port A overrides any lane that both ports write.
  // NOTE: the memory has no reset term. That lets it map onto block RAM.
  // The contents survive reset; only the enables are gated while in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_COL; i++) begin
        // NOTE: non-blocking writes. Every read in this cycle sees the
        // pre-write word. When both ports target one lane, the later
        // assignment (port A) is the one that takes effect.
        if (enaB && weB[i]) mem[addrB][i*COL_WIDTH +: COL_WIDTH] <= dinB[i*COL_WIDTH +: COL_WIDTH];
        if (enaA && weA[i]) mem[addrA][i*COL_WIDTH +: COL_WIDTH] <= dinA[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Stage-1 candidates. The base is the pre-write word. A WRITE_FIRST port
  // then merges in its own written lanes.
  always_comb begin
    // NOTE: every variable gets a full default before any conditional
    // update. That keeps this block free of inferred latches.
    memRdA  = mem[addrA];
    memRdB  = mem[addrB];
    s1NextA = memRdA;
    s1NextB = memRdB;
    for (int i = 0; i < NUM_COL; i++) begin
      if (IS_WF_A && weA[i]) s1NextA[i*COL_WIDTH +: COL_WIDTH] = dinA[i*COL_WIDTH +: COL_WIDTH];
      if (IS_WF_B && weB[i]) s1NextB[i*COL_WIDTH +: COL_WIDTH] = dinB[i*COL_WIDTH +: COL_WIDTH];
    end
    rdAccA = enaA && (!IS_NC_A || (weA == '0));
    rdAccB = enaB && (!IS_NC_B || (weB == '0));
  end

  // Stage 1: memory output register. It loads only on a read access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1A   <= '0;
      s1B   <= '0;
      vld1A <= 1'b0;
      vld1B <= 1'b0;
    end else begin
      vld1A <= rdAccA;
      vld1B <= rdAccB;
      if (rdAccA) s1A <= s1NextA;
      if (rdAccB) s1B <= s1NextB;
    end
  end

  assign collNow = enaA && enaB && (addrA == addrB) && ((weA & weB) != '0);

  // Collision flag: a one-cycle pulse after two writes hit overlapping lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) coll <= 1'b0;
    else        coll <= collNow;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2A, s2B;
      logic                  vld2A, vld2B;

      // Stage 2: output register gated by regce. A read that regce does
      // not capture is dropped.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2A   <= '0;
          s2B   <= '0;
          vld2A <= 1'b0;
          vld2B <= 1'b0;
        end else begin
          vld2A <= vld1A & regceA;
          vld2B <= vld1B & regceB;
          if (regceA) s2A <= s1A;
          if (regceB) s2B <= s1B;
        end
      end

      assign doutA     = s2A;
      assign doutB     = s2B;
      assign doutA_vld = vld2A;
      assign doutB_vld = vld2B;
    end else begin : g_lat1
      // regce has no effect at latency 1.
      logic unusedRegce;
      assign unusedRegce = regceA ^ regceB;

      assign doutA     = s1A;
      assign doutB     = s1B;
      assign doutA_vld = vld1A;
      assign doutB_vld = vld1B;
    end
  endgenerate

endmodule

// File: tb/tb_bytewrite_tdp_ram_mode.sv
// Bench for bytewrite_tdp_ram_mode. It uses three instances:
//   0: A=NO_CHANGE,   B=READ_FIRST, latency 1
//   1: A=WRITE_FIRST, B=NO_CHANGE,  latency 1
//   2: A=READ_FIRST,  B=READ_FIRST, latency 2
// Expected read data goes into per-port queues when the read is issued.
// Each entry is popped when that port raises its valid strobe.
module tb_bytewrite_tdp_ram_mode;

  localparam int   ND = 3;
  localparam logic Y  = 1'b1;
  localparam logic N  = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enaA [ND];
  logic        enaB [ND];
  logic        regceA [ND];
  logic        regceB [ND];
  logic [3:0]  weA [ND];
  logic [3:0]  weB [ND];
  logic [9:0]  addrA [ND];
  logic [9:0]  addrB [ND];
  logic [31:0] dinA [ND];
  logic [31:0] dinB [ND];
  logic [31:0] doutA [ND];
  logic [31:0] doutB [ND];
  logic        doutA_vld [ND];
  logic        doutB_vld [ND];
  logic        coll [ND];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] qA [$];
  logic [31:0] qB [$];

  typedef struct {
    logic enA; logic [3:0] wA; logic [9:0] aA; logic [31:0] dA; logic rcA;
    logic enB; logic [3:0] wB; logic [9:0] aB; logic [31:0] dB; logic rcB;
  } stim_t;

  // pX/eX: push eX at issue. vX: expected strobe. c: expected coll.
  // hA/hvA: doutA must equal hvA (hold check).
  typedef struct {
    logic pA; logic [31:0] eA; logic pB; logic [31:0] eB;
    logic vA; logic vB; logic c; logic hA; logic [31:0] hvA;
  } exp_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    bytewrite_tdp_ram_mode #(
      .NUM_COL     (4),
      .COL_WIDTH   (8),
      .ADDR_WIDTH  (10),
      .WRITE_MODE_A(g == 0 ? 0 : (g == 1 ? 2 : 1)),
      .WRITE_MODE_B(g == 1 ? 0 : 1),
      .READ_LATENCY(g == 2 ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enaA     (enaA[g]),
      .weA      (weA[g]),
      .addrA    (addrA[g]),
      .dinA     (dinA[g]),
      .regceA   (regceA[g]),
      .doutA    (doutA[g]),
      .doutA_vld(doutA_vld[g]),
      .enaB     (enaB[g]),
      .weB      (weB[g]),
      .addrB    (addrB[g]),
      .dinB     (dinB[g]),
      .regceB   (regceB[g]),
      .doutB    (doutB[g]),
      .doutB_vld(doutB_vld[g]),
      .coll     (coll[g])
    );
  end

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      enaA[d] = N; weA[d] = '0; addrA[d] = '0; dinA[d] = '0; regceA[d] = N;
      enaB[d] = N; weB[d] = '0; addrB[d] = '0; dinB[d] = '0; regceB[d] = N;
    end
  endtask

  task automatic drive(input int d, input stim_t s);
    enaA[d] = s.enA; weA[d] = s.wA; addrA[d] = s.aA; dinA[d] = s.dA; regceA[d] = s.rcA;
    enaB[d] = s.enB; weB[d] = s.wB; addrB[d] = s.aB; dinB[d] = s.dB; regceB[d] = s.rcB;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      enaA[d] = Y; weA[d] = 4'hF; addrA[d] = 10'd5; dinA[d] = 32'hDEADBEEF;
    end
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      total++; if (doutA[d] !== 32'h0) begin bad++; $display("FAIL reset_doutA dut%0d: got %h want 0", d, doutA[d]); end
      total++; if (doutB[d] !== 32'h0) begin bad++; $display("FAIL reset_doutB dut%0d: got %h want 0", d, doutB[d]); end
      total++; if (doutA_vld[d] !== 1'b0) begin bad++; $display("FAIL reset_vldA dut%0d: got %b want 0", d, doutA_vld[d]); end
      total++; if (doutB_vld[d] !== 1'b0) begin bad++; $display("FAIL reset_vldB dut%0d: got %b want 0", d, doutB_vld[d]); end
      total++; if (coll[d] !== 1'b0) begin bad++; $display("FAIL reset_coll dut%0d: got %b want 0", d, coll[d]); end
    end
    idle_all();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      enaA[d] = Y; weA[d] = 4'h0; addrA[d] = 10'd5;
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      total++; if (doutA_vld[d] !== 1'b1) begin bad++; $display("FAIL reset_read_vld dut%0d: got %b want 1", d, doutA_vld[d]); end
      total++; if (doutA[d] === 32'hDEADBEEF) begin bad++; $display("FAIL reset_nowrite dut%0d: got %h want not deadbeef", d, doutA[d]); end
    end
    idle_all();
    tick();
  endtask

  task automatic test_byte_write();
    stim_t s [6];
    exp_t  e [6];
    logic [31:0] x;
    s[0] = '{Y, 4'hF, 10'd4, 32'h55667788, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[1] = '{Y, 4'h0, 10'd4, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    s[2] = '{Y, 4'hF, 10'd3, 32'h11223344, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[3] = '{Y, 4'h2, 10'd3, 32'hAAAAAAAA, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[4] = '{N, 4'h0, 10'd0, 32'h0,        N,  Y, 4'h0, 10'd3, 32'h0, N};
    s[5] = '{N, 4'h0, 10'd0, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    e[0] = '{N, 32'h0,        N, 32'h0,        N, N, N, N, 32'h0};
    e[1] = '{Y, 32'h55667788, N, 32'h0,        Y, N, N, N, 32'h0};
    e[2] = '{N, 32'h0,        N, 32'h0,        N, N, N, Y, 32'h55667788};
    e[3] = '{N, 32'h0,        N, 32'h0,        N, N, N, Y, 32'h55667788};
    e[4] = '{N, 32'h0,        Y, 32'h1122AA44, N, Y, N, Y, 32'h55667788};
    e[5] = '{N, 32'h0,        N, 32'h0,        N, N, N, N, 32'h0};
    qA.delete(); qB.delete();
    for (int i = 0; i < 6; i++) begin
      drive(0, s[i]);
      if (e[i].pA) qA.push_back(e[i].eA);
      if (e[i].pB) qB.push_back(e[i].eB);
      tick();
      total++; if (doutA_vld[0] !== e[i].vA) begin bad++; $display("FAIL byte_write vldA cyc%0d: got %b want %b", i, doutA_vld[0], e[i].vA); end
      total++; if (doutB_vld[0] !== e[i].vB) begin bad++; $display("FAIL byte_write vldB cyc%0d: got %b want %b", i, doutB_vld[0], e[i].vB); end
      total++; if (coll[0] !== e[i].c) begin bad++; $display("FAIL byte_write coll cyc%0d: got %b want %b", i, coll[0], e[i].c); end
      if (e[i].hA) begin
        total++; if (doutA[0] !== e[i].hvA) begin bad++; $display("FAIL byte_write holdA cyc%0d: got %h want %h", i, doutA[0], e[i].hvA); end
      end
      if (doutA_vld[0] === 1'b1 && qA.size() > 0) begin
        x = qA.pop_front();
        total++; if (doutA[0] !== x) begin bad++; $display("FAIL byte_write doutA cyc%0d: got %h want %h", i, doutA[0], x); end
      end
      if (doutB_vld[0] === 1'b1 && qB.size() > 0) begin
        x = qB.pop_front();
        total++; if (doutB[0] !== x) begin bad++; $display("FAIL byte_write doutB cyc%0d: got %h want %h", i, doutB[0], x); end
      end
    end
    total++; if (qA.size() + qB.size() != 0) begin bad++; $display("FAIL byte_write leftover: got %0d want 0", qA.size() + qB.size()); end
  endtask

  task automatic test_write_first();
    stim_t s [4];
    exp_t  e [4];
    logic [31:0] x;
    s[0] = '{Y, 4'hF, 10'd7, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    s[1] = '{Y, 4'h9, 10'd7, 32'h12345678, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[2] = '{Y, 4'h0, 10'd7, 32'h0,        N,  Y, 4'h0, 10'd7, 32'h0, N};
    s[3] = '{N, 4'h0, 10'd0, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    e[0] = '{Y, 32'h0,        N, 32'h0,        Y, N, N, N, 32'h0};
    e[1] = '{Y, 32'h12000078, N, 32'h0,        Y, N, N, N, 32'h0};
    e[2] = '{Y, 32'h12000078, Y, 32'h12000078, Y, Y, N, N, 32'h0};
    e[3] = '{N, 32'h0,        N, 32'h0,        N, N, N, Y, 32'h12000078};
    qA.delete(); qB.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, s[i]);
      if (e[i].pA) qA.push_back(e[i].eA);
      if (e[i].pB) qB.push_back(e[i].eB);
      tick();
      total++; if (doutA_vld[1] !== e[i].vA) begin bad++; $display("FAIL write_first vldA cyc%0d: got %b want %b", i, doutA_vld[1], e[i].vA); end
      total++; if (doutB_vld[1] !== e[i].vB) begin bad++; $display("FAIL write_first vldB cyc%0d: got %b want %b", i, doutB_vld[1], e[i].vB); end
      total++; if (coll[1] !== e[i].c) begin bad++; $display("FAIL write_first coll cyc%0d: got %b want %b", i, coll[1], e[i].c); end
      if (e[i].hA) begin
        total++; if (doutA[1] !== e[i].hvA) begin bad++; $display("FAIL write_first holdA cyc%0d: got %h want %h", i, doutA[1], e[i].hvA); end
      end
      if (doutA_vld[1] === 1'b1 && qA.size() > 0) begin
        x = qA.pop_front();
        total++; if (doutA[1] !== x) begin bad++; $display("FAIL write_first doutA cyc%0d: got %h want %h", i, doutA[1], x); end
      end
      if (doutB_vld[1] === 1'b1 && qB.size() > 0) begin
        x = qB.pop_front();
        total++; if (doutB[1] !== x) begin bad++; $display("FAIL write_first doutB cyc%0d: got %h want %h", i, doutB[1], x); end
      end
    end
    total++; if (qA.size() + qB.size() != 0) begin bad++; $display("FAIL write_first leftover: got %0d want 0", qA.size() + qB.size()); end
  endtask

  task automatic test_collision();
    stim_t s [5];
    exp_t  e [5];
    logic [31:0] x;
    s[0] = '{Y, 4'hF, 10'd9, 32'h01020304, N,  N, 4'h0, 10'd0, 32'h0,        N};
    s[1] = '{Y, 4'h3, 10'd9, 32'hAAAAAAAA, N,  Y, 4'h6, 10'd9, 32'hBBBBBBBB, N};
    s[2] = '{Y, 4'h0, 10'd9, 32'h0,        N,  Y, 4'h0, 10'd9, 32'h0,        N};
    s[3] = '{Y, 4'hF, 10'd9, 32'h0,        N,  Y, 4'h0, 10'd9, 32'h0,        N};
    s[4] = '{N, 4'h0, 10'd0, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0,        N};
    e[0] = '{N, 32'h0,        N, 32'h0,        N, N, N, N, 32'h0};
    e[1] = '{N, 32'h0,        Y, 32'h01020304, N, Y, Y, N, 32'h0};
    e[2] = '{Y, 32'h01BBAAAA, Y, 32'h01BBAAAA, Y, Y, N, N, 32'h0};
    e[3] = '{N, 32'h0,        Y, 32'h01BBAAAA, N, Y, N, Y, 32'h01BBAAAA};
    e[4] = '{N, 32'h0,        N, 32'h0,        N, N, N, N, 32'h0};
    qA.delete(); qB.delete();
    for (int i = 0; i < 5; i++) begin
      drive(0, s[i]);
      if (e[i].pA) qA.push_back(e[i].eA);
      if (e[i].pB) qB.push_back(e[i].eB);
      tick();
      total++; if (doutA_vld[0] !== e[i].vA) begin bad++; $display("FAIL collision vldA cyc%0d: got %b want %b", i, doutA_vld[0], e[i].vA); end
      total++; if (doutB_vld[0] !== e[i].vB) begin bad++; $display("FAIL collision vldB cyc%0d: got %b want %b", i, doutB_vld[0], e[i].vB); end
      total++; if (coll[0] !== e[i].c) begin bad++; $display("FAIL collision coll cyc%0d: got %b want %b", i, coll[0], e[i].c); end
      if (e[i].hA) begin
        total++; if (doutA[0] !== e[i].hvA) begin bad++; $display("FAIL collision holdA cyc%0d: got %h want %h", i, doutA[0], e[i].hvA); end
      end
      if (doutA_vld[0] === 1'b1 && qA.size() > 0) begin
        x = qA.pop_front();
        total++; if (doutA[0] !== x) begin bad++; $display("FAIL collision doutA cyc%0d: got %h want %h", i, doutA[0], x); end
      end
      if (doutB_vld[0] === 1'b1 && qB.size() > 0) begin
        x = qB.pop_front();
        total++; if (doutB[0] !== x) begin bad++; $display("FAIL collision doutB cyc%0d: got %h want %h", i, doutB[0], x); end
      end
    end
    total++; if (qA.size() + qB.size() != 0) begin bad++; $display("FAIL collision leftover: got %0d want 0", qA.size() + qB.size()); end
  endtask

  task automatic test_cross_port();
    stim_t s [4];
    exp_t  e [4];
    logic [31:0] x;
    s[0] = '{Y, 4'hF, 10'd2, 32'h0, N,  N, 4'h0, 10'd0, 32'h0,        N};
    s[1] = '{Y, 4'h0, 10'd2, 32'h0, N,  Y, 4'hF, 10'd2, 32'hCAFEF00D, N};
    s[2] = '{Y, 4'h0, 10'd2, 32'h0, N,  N, 4'h0, 10'd0, 32'h0,        N};
    s[3] = '{N, 4'h0, 10'd0, 32'h0, N,  N, 4'h0, 10'd0, 32'h0,        N};
    e[0] = '{N, 32'h0,        N, 32'h0, N, N, N, N, 32'h0};
    e[1] = '{Y, 32'h0,        Y, 32'h0, Y, Y, N, N, 32'h0};
    e[2] = '{Y, 32'hCAFEF00D, N, 32'h0, Y, N, N, N, 32'h0};
    e[3] = '{N, 32'h0,        N, 32'h0, N, N, N, Y, 32'hCAFEF00D};
    qA.delete(); qB.delete();
    for (int i = 0; i < 4; i++) begin
      drive(0, s[i]);
      if (e[i].pA) qA.push_back(e[i].eA);
      if (e[i].pB) qB.push_back(e[i].eB);
      tick();
      total++; if (doutA_vld[0] !== e[i].vA) begin bad++; $display("FAIL cross_port vldA cyc%0d: got %b want %b", i, doutA_vld[0], e[i].vA); end
      total++; if (doutB_vld[0] !== e[i].vB) begin bad++; $display("FAIL cross_port vldB cyc%0d: got %b want %b", i, doutB_vld[0], e[i].vB); end
      total++; if (coll[0] !== e[i].c) begin bad++; $display("FAIL cross_port coll cyc%0d: got %b want %b", i, coll[0], e[i].c); end
      if (e[i].hA) begin
        total++; if (doutA[0] !== e[i].hvA) begin bad++; $display("FAIL cross_port holdA cyc%0d: got %h want %h", i, doutA[0], e[i].hvA); end
      end
      if (doutA_vld[0] === 1'b1 && qA.size() > 0) begin
        x = qA.pop_front();
        total++; if (doutA[0] !== x) begin bad++; $display("FAIL cross_port doutA cyc%0d: got %h want %h", i, doutA[0], x); end
      end
      if (doutB_vld[0] === 1'b1 && qB.size() > 0) begin
        x = qB.pop_front();
        total++; if (doutB[0] !== x) begin bad++; $display("FAIL cross_port doutB cyc%0d: got %h want %h", i, doutB[0], x); end
      end
    end
    total++; if (qA.size() + qB.size() != 0) begin bad++; $display("FAIL cross_port leftover: got %0d want 0", qA.size() + qB.size()); end
  endtask

  // The address is driven in cycle t. The regce for that read goes with
  // cycle t+1, when its data sits in stage 1.
  task automatic test_latency2();
    stim_t s [8];
    exp_t  e [8];
    logic [31:0] x;
    s[0] = '{Y, 4'hF, 10'd0, 32'hA0A0A0A0, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[1] = '{Y, 4'hF, 10'd1, 32'hB1B1B1B1, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[2] = '{Y, 4'hF, 10'd2, 32'hC2C2C2C2, N,  N, 4'h0, 10'd0, 32'h0, N};
    s[3] = '{Y, 4'h0, 10'd0, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    s[4] = '{Y, 4'h0, 10'd1, 32'h0,        Y,  N, 4'h0, 10'd0, 32'h0, N};
    s[5] = '{Y, 4'h0, 10'd2, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    s[6] = '{N, 4'h0, 10'd0, 32'h0,        Y,  N, 4'h0, 10'd0, 32'h0, N};
    s[7] = '{N, 4'h0, 10'd0, 32'h0,        N,  N, 4'h0, 10'd0, 32'h0, N};
    e[0] = '{N, 32'h0,        N, 32'h0, N, N, N, N, 32'h0};
    e[1] = '{N, 32'h0,        N, 32'h0, N, N, N, N, 32'h0};
    e[2] = '{N, 32'h0,        N, 32'h0, N, N, N, N, 32'h0};
    e[3] = '{Y, 32'hA0A0A0A0, N, 32'h0, N, N, N, N, 32'h0};
    e[4] = '{N, 32'h0,        N, 32'h0, Y, N, N, N, 32'h0};
    e[5] = '{Y, 32'hC2C2C2C2, N, 32'h0, N, N, N, Y, 32'hA0A0A0A0};
    e[6] = '{N, 32'h0,        N, 32'h0, Y, N, N, N, 32'h0};
    e[7] = '{N, 32'h0,        N, 32'h0, N, N, N, Y, 32'hC2C2C2C2};
    qA.delete(); qB.delete();
    for (int i = 0; i < 8; i++) begin
      drive(2, s[i]);
      if (e[i].pA) qA.push_back(e[i].eA);
      if (e[i].pB) qB.push_back(e[i].eB);
      tick();
      total++; if (doutA_vld[2] !== e[i].vA) begin bad++; $display("FAIL latency2 vldA cyc%0d: got %b want %b", i, doutA_vld[2], e[i].vA); end
      total++; if (doutB_vld[2] !== e[i].vB) begin bad++; $display("FAIL latency2 vldB cyc%0d: got %b want %b", i, doutB_vld[2], e[i].vB); end
      total++; if (coll[2] !== e[i].c) begin bad++; $display("FAIL latency2 coll cyc%0d: got %b want %b", i, coll[2], e[i].c); end
      if (e[i].hA) begin
        total++; if (doutA[2] !== e[i].hvA) begin bad++; $display("FAIL latency2 holdA cyc%0d: got %h want %h", i, doutA[2], e[i].hvA); end
      end
      if (doutA_vld[2] === 1'b1 && qA.size() > 0) begin
        x = qA.pop_front();
        total++; if (doutA[2] !== x) begin bad++; $display("FAIL latency2 doutA cyc%0d: got %h want %h", i, doutA[2], x); end
      end
      if (doutB_vld[2] === 1'b1 && qB.size() > 0) begin
        x = qB.pop_front();
        total++; if (doutB[2] !== x) begin bad++; $display("FAIL latency2 doutB cyc%0d: got %h want %h", i, doutB[2], x); end
      end
    end
    total++; if (qA.size() + qB.size() != 0) begin bad++; $display("FAIL latency2 leftover: got %0d want 0", qA.size() + qB.size()); end
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    test_reset();
    test_byte_write();
    test_write_first();
    test_collision();
    test_cross_port();
    test_latency2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
